hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_reg_tracker.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 90 +++++++++
 tb/tb_hazard_scoreboard.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared widths and latency helpers for the register hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned MAX_LAT_DEF  = 4;
  localparam int unsigned REG_W        = $clog2(NUM_REGS_DEF);
  localparam int unsigned LAT_W        = $clog2(MAX_LAT_DEF + 1);

  // Saturate a latency to an upper bound (used for both wb saturation and fwd clamp).
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned lim);
    return (lat > lim) ? lim : lat;
  endfunction

endpackage

// File: rtl/hazard_reg_tracker.sv
// Per-register pair of countdown counters: cycles until forwardable and until written back.
module hazard_reg_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [CNT_W-1:0] fwd_ld,
  input  logic [CNT_W-1:0] wb_ld,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  // A load replaces the decrement so a new writer fully owns the register.
  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    wb_cnt_d  = wb_cnt_q;
    if (fwd_cnt_q != '0) fwd_cnt_d = fwd_cnt_q - CNT_W'(1);
    if (wb_cnt_q != '0)  wb_cnt_d  = wb_cnt_q - CNT_W'(1);
    if (load_en) begin
      fwd_cnt_d = fwd_ld;
      wb_cnt_d  = wb_ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  assign fwd_cnt = fwd_cnt_q;
  assign wb_cnt  = wb_cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW hazard scoreboard with per-register forward/writeback countdowns.
// Optional stall-cycle statistics counter enabled by macro HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned MAX_LAT  = MAX_LAT_DEF,
  localparam int unsigned RW      = $clog2(NUM_REGS),
  localparam int unsigned LW      = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic [RW-1:0]         issue_dest,
  input  logic [LW-1:0]         issue_fwd_lat,
  input  logic [LW-1:0]         issue_wb_lat,
  input  logic [NUM_SRC*RW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]    src_en,
  input  logic                  fwd_en,
  input  logic                  flush,
  output logic                  stall,
  output logic [NUM_SRC-1:0]    hazard_src,
  output logic [NUM_REGS-1:0]   busy_mask
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic [LW-1:0] fwd_cnt [NUM_REGS];
  logic [LW-1:0] wb_cnt  [NUM_REGS];
  logic [LW-1:0] wb_ld;
  logic [LW-1:0] fwd_ld;
  logic          accept;

  // Forwarding can never be later than the writeback itself.
  always_comb begin
    wb_ld  = LW'(clamp_lat(32'(issue_wb_lat), MAX_LAT));
    fwd_ld = LW'(clamp_lat(32'(issue_fwd_lat), 32'(wb_ld)));
  end

  // Hazards look only at registered counters, so a self-dependent issue sees pre-load state.
  always_comb begin
    logic [RW-1:0] src;
    src        = '0;
    hazard_src = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src           = src_addr[i*RW +: RW];
      hazard_src[i] = src_en[i] && (fwd_en ? (fwd_cnt[src] != '0) : (wb_cnt[src] != '0));
    end
  end

  assign stall  = issue_valid && !flush && (|hazard_src);
  assign accept = issue_valid && !stall && !flush && issue_wb_en;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_trk
    hazard_reg_tracker #(
      .CNT_W (LW)
    ) u_trk (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (accept && (issue_dest == RW'(r))),
      .fwd_ld  (fwd_ld),
      .wb_ld   (wb_ld),
      .fwd_cnt (fwd_cnt[r]),
      .wb_cnt  (wb_cnt[r])
    );
    assign busy_mask[r] = (wb_cnt[r] != '0);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random issue traffic
// compared against a timestamp-based model (a register is pending until an absolute cycle).
module tb_hazard_scoreboard;

  localparam int NR = 16;
  localparam int NS = 3;
  localparam int ML = 4;
  localparam int RW = 4;
  localparam int LW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_wb_en = 1'b0;
  logic [RW-1:0]    issue_dest = '0;
  logic [LW-1:0]    issue_fwd_lat = '0;
  logic [LW-1:0]    issue_wb_lat = '0;
  logic [NS*RW-1:0] src_addr = '0;
  logic [NS-1:0]    src_en = '0;
  logic             fwd_en = 1'b0;
  logic             flush = 1'b0;
  logic             stall;
  logic [NS-1:0]    hazard_src;
  logic [NR-1:0]    busy_mask;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  hazard_scoreboard #(
    .NUM_REGS (NR),
    .NUM_SRC  (NS),
    .MAX_LAT  (ML)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_wb_en   (issue_wb_en),
    .issue_dest    (issue_dest),
    .issue_fwd_lat (issue_fwd_lat),
    .issue_wb_lat  (issue_wb_lat),
    .src_addr      (src_addr),
    .src_en        (src_en),
    .fwd_en        (fwd_en),
    .flush         (flush),
    .stall         (stall),
    .hazard_src    (hazard_src),
    .busy_mask     (busy_mask)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          fwd_done [NR];
  int          wb_done  [NR];
  int unsigned stall_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] model_haz();
    logic [NS-1:0] h;
    int            s;
    h = '0;
    for (int i = 0; i < NS; i++) begin
      s    = int'(src_addr[i*RW +: RW]);
      h[i] = src_en[i] && (fwd_en ? (cyc < fwd_done[s]) : (cyc < wb_done[s]));
    end
    return h;
  endfunction

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b;
    for (int r = 0; r < NR; r++) b[r] = (cyc < wb_done[r]);
    return b;
  endfunction

  function automatic logic model_stall();
    return issue_valid && !flush && (|model_haz());
  endfunction

  function automatic logic [NS*RW-1:0] srcs(input int a, input int b, input int c);
    return {RW'(c), RW'(b), RW'(a)};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      fwd_done[r] = 0;
      wb_done[r]  = 0;
    end
    stall_model = 0;
  endtask

  task automatic recheck();
    #1;
    check("stall", 32'(stall), 32'(model_stall()));
    check("hazard_src", 32'(hazard_src), 32'(model_haz()));
    check("busy_mask", 32'(busy_mask), 32'(model_busy()));
`ifdef HAZARD_STATS_EN
    check("stall_cycles", stall_cycles, stall_model);
`endif
  endtask

  task automatic drive(input logic v, input logic we, input int dest, input int fl, input int wl,
                       input logic [NS*RW-1:0] sa, input logic [NS-1:0] se, input logic fe,
                       input logic fsh);
    issue_valid   = v;
    issue_wb_en   = we;
    issue_dest    = RW'(dest);
    issue_fwd_lat = LW'(fl);
    issue_wb_lat  = LW'(wl);
    src_addr      = sa;
    src_en        = se;
    fwd_en        = fe;
    flush         = fsh;
    recheck();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, '0, '0, 1'b0, 1'b0);
  endtask

  // Advance one clock; an accepted write becomes pending until cyc + latency.
  task automatic tick();
    logic es, acc;
    int   wbv, fv, d;
    es  = model_stall();
    acc = issue_valid && !es && !flush && issue_wb_en;
    wbv = (int'(issue_wb_lat) > ML) ? ML : int'(issue_wb_lat);
    fv  = (int'(issue_fwd_lat) < wbv) ? int'(issue_fwd_lat) : wbv;
    d   = int'(issue_dest);
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      if (acc) begin
        fwd_done[d] = cyc + fv;
        wb_done[d]  = cyc + wbv;
      end
      if (es && stall_model != 32'hFFFF_FFFF) stall_model++;
    end
    @(negedge clk);
  endtask

  task automatic wait_accept(input string tag);
    int k = 0;
    while (stall === 1'b1 && k < 10) begin
      tick();
      recheck();
      k++;
    end
    check(tag, 32'(stall), 32'd0);
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) begin
      idle();
      tick();
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);

    // Reset holds all outputs low even with a hazard-shaped request.
    drive(1'b1, 1'b1, 3, 2, 3, srcs(3, 3, 3), 3'b111, 1'b0, 1'b0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy_mask), 32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // Load-use with forwarding.
    drive(1'b1, 1'b1, 3, 2, 3, '0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, srcs(3, 0, 0), 3'b001, 1'b1, 1'b0);
    check("ldu_fwd_stall", 32'(stall), 32'd1);
    wait_accept("ldu_fwd_accept");
    drain();

    // Same producer without forwarding; writeback busy window is three cycles.
    drive(1'b1, 1'b1, 3, 2, 3, '0, '0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      idle();
      check($sformatf("nofwd_busy3_c%0d", k), 32'(busy_mask[3]), (k < 3) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 3, 2, 3, '0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, srcs(0, 3, 0), 3'b010, 1'b0, 1'b0);
    check("ldu_nofwd_stall", 32'(stall), 32'd1);
    wait_accept("ldu_nofwd_accept");
    drain();

    // Flushed issue never loads; a stalled issue under flush does not stall.
    drive(1'b1, 1'b1, 5, 0, 3, '0, '0, 1'b0, 1'b1);
    tick();
    idle();
    check("flush_busy5", 32'(busy_mask[5]), 32'd0);
    drive(1'b1, 1'b1, 5, 0, 3, '0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, srcs(5, 0, 0), 3'b001, 1'b0, 1'b1);
    check("flush_nostall", 32'(stall), 32'd0);
    tick();
    drain();

    // Latency saturation, then write-after-write overwrite while busy.
    drive(1'b1, 1'b1, 2, 7, 7, '0, '0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      idle();
      check($sformatf("sat_busy2_c%0d", k), 32'(busy_mask[2]), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 2, 1, 2, '0, '0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b1, 1'b1, 2, 1, 4, '0, '0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      idle();
      check($sformatf("waw_busy2_c%0d", k), 32'(busy_mask[2]), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    drain();

    // Self-dependency: source checked against the pending old write, not its own load.
    drive(1'b1, 1'b1, 7, 1, 2, '0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 7, 1, 2, srcs(7, 0, 0), 3'b001, 1'b0, 1'b0);
    check("self_dep_stall", 32'(stall), 32'd1);
    wait_accept("self_dep_accept");
    drive(1'b1, 1'b0, 0, 0, 0, srcs(7, 0, 0), 3'b001, 1'b0, 1'b0);
    check("self_dep_loaded", 32'(stall), 32'd1);
    drain();

    // Reset mid-operation discards pending writes.
    drive(1'b1, 1'b1, 1, 4, 4, '0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, srcs(1, 0, 0), 3'b001, 1'b0, 1'b0);
    tick();
    recheck();
    rst_n = 1'b0;
    model_clear();
    recheck();
    check("midrst_busy", 32'(busy_mask), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    tick();
    recheck();
    rst_n = 1'b1;
    idle();
    drive(1'b1, 1'b1, 1, 4, 4, '0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 0, 0, 0, srcs(1, 0, 0), 3'b001, 1'b0, 1'b0);
    tick();
    recheck();
    tick();
    idle();
`ifdef HAZARD_STATS_EN
    check("stats_two", stall_cycles, 32'd2);
`endif
    drain();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, NR - 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            srcs(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                 int'($urandom_range(0, NR - 1))),
            NS'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
